// File: rtl/mor1kx_bus_if_wbn.sv
// Bridges one mor1kx CPU bus port to a Wishbone B3 master. Latency: cyc/stb one cycle after
// cpu_req_i; cpu_ack_o/cpu_err_o one cycle after the slave response. The slave stalls by delaying ack.
module mor1kx_bus_if_wbn #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    ADDR_WIDTH   = 32,
  parameter string MODE         = "B3_BURST",
  parameter int    BURST_LENGTH = 8,
  parameter int    RETRY_MAX    = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ADDR_WIDTH-1:0]   cpu_adr_i,
  input  logic [DATA_WIDTH-1:0]   cpu_dat_i,
  input  logic                    cpu_req_i,
  input  logic [DATA_WIDTH/8-1:0] cpu_bsel_i,
  input  logic                    cpu_we_i,
  input  logic                    cpu_burst_i,
  output logic [DATA_WIDTH-1:0]   cpu_dat_o,
  output logic                    cpu_ack_o,
  output logic                    cpu_err_o,
  output logic [ADDR_WIDTH-1:0]   wbm_adr_o,
  output logic [DATA_WIDTH-1:0]   wbm_dat_o,
  output logic [DATA_WIDTH/8-1:0] wbm_sel_o,
  output logic                    wbm_we_o,
  output logic                    wbm_cyc_o,
  output logic                    wbm_stb_o,
  output logic [2:0]              wbm_cti_o,
  output logic [1:0]              wbm_bte_o,
  input  logic [DATA_WIDTH-1:0]   wbm_dat_i,
  input  logic                    wbm_ack_i,
  input  logic                    wbm_err_i,
  input  logic                    wbm_rty_i,
  output logic                    busy_o
);

  localparam int BYTES    = DATA_WIDTH / 8;
  localparam bit B3       = (MODE == "B3_BURST");
  localparam bit BURST_EN = B3 && (BURST_LENGTH > 1);
  localparam logic [ADDR_WIDTH-1:0] STEP      = ADDR_WIDTH'(BYTES);
  localparam logic [ADDR_WIDTH-1:0] WRAP_MASK = ADDR_WIDTH'(BURST_LENGTH * BYTES - 1);
  localparam logic [1:0] BTE = (BURST_LENGTH == 4)  ? 2'b01 :
                               (BURST_LENGTH == 8)  ? 2'b10 :
                               (BURST_LENGTH == 16) ? 2'b11 : 2'b00;
  localparam logic [2:0] CTI_SINGLE = B3 ? 3'b111 : 3'b000;
  localparam logic [4:0] LAST_BEAT  = 5'(BURST_LENGTH - 1);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);
  localparam logic [RW-1:0] RMAX = RW'(RETRY_MAX);

  typedef enum logic [2:0] {ST_IDLE, ST_SINGLE, ST_BURST, ST_RETRY, ST_DONE} state_t;

  state_t                  state_q, ret_state_q;
  logic [ADDR_WIDTH-1:0]   adr_q, adr_d;
  logic [DATA_WIDTH-1:0]   dat_q, cpu_dat_q;
  logic [DATA_WIDTH/8-1:0] sel_q;
  logic                    we_q, cyc_q, stb_q, cpu_ack_q, cpu_err_q, busy_q;
  logic [2:0]              cti_q;
  logic [1:0]              bte_q;
  logic [4:0]              beat_q;
  logic [RW-1:0]           rty_cnt_q;
  logic                    rty_fail;

  // Next beat address wraps inside the aligned burst block, upper bits untouched.
  assign adr_d    = (adr_q & ~WRAP_MASK) | ((adr_q + STEP) & WRAP_MASK);
  assign rty_fail = wbm_rty_i && (rty_cnt_q == RMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      ret_state_q <= ST_IDLE;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      we_q        <= 1'b0;
      cyc_q       <= 1'b0;
      stb_q       <= 1'b0;
      cti_q       <= 3'b000;
      bte_q       <= 2'b00;
      cpu_dat_q   <= '0;
      cpu_ack_q   <= 1'b0;
      cpu_err_q   <= 1'b0;
      busy_q      <= 1'b0;
      beat_q      <= '0;
      rty_cnt_q   <= '0;
    end else begin
      cpu_ack_q <= 1'b0;
      cpu_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (cpu_req_i) begin
            adr_q     <= cpu_adr_i;
            dat_q     <= cpu_dat_i;
            sel_q     <= cpu_bsel_i;
            we_q      <= cpu_we_i;
            cyc_q     <= 1'b1;
            stb_q     <= 1'b1;
            busy_q    <= 1'b1;
            beat_q    <= '0;
            rty_cnt_q <= '0;
            if (BURST_EN && cpu_burst_i && !cpu_we_i) begin
              state_q <= ST_BURST;
              cti_q   <= 3'b010;
              bte_q   <= BTE;
            end else begin
              state_q <= ST_SINGLE;
              cti_q   <= CTI_SINGLE;
              bte_q   <= 2'b00;
            end
          end
        end
        ST_SINGLE, ST_BURST: begin
          if (cyc_q && stb_q) begin
            // err beats ack beats rty; exhausted retries report as err
            if (wbm_err_i || (!wbm_ack_i && rty_fail)) begin
              cpu_err_q <= 1'b1;
              cyc_q     <= 1'b0;
              stb_q     <= 1'b0;
              rty_cnt_q <= '0;
              state_q   <= ST_DONE;
            end else if (wbm_ack_i) begin
              cpu_dat_q <= wbm_dat_i;
              cpu_ack_q <= 1'b1;
              rty_cnt_q <= '0;
              if (state_q == ST_SINGLE || beat_q == LAST_BEAT) begin
                cyc_q   <= 1'b0;
                stb_q   <= 1'b0;
                state_q <= ST_DONE;
              end else begin
                beat_q <= beat_q + 5'd1;
                adr_q  <= adr_d;
                cti_q  <= ((beat_q + 5'd1) == LAST_BEAT) ? 3'b111 : 3'b010;
              end
            end else if (wbm_rty_i) begin
              rty_cnt_q   <= rty_cnt_q + 1'b1;
              cyc_q       <= 1'b0;
              stb_q       <= 1'b0;
              ret_state_q <= state_q;
              state_q     <= ST_RETRY;
            end
          end
        end
        ST_RETRY: begin
          cyc_q   <= 1'b1;
          stb_q   <= 1'b1;
          state_q <= ret_state_q;
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign cpu_dat_o = cpu_dat_q;
  assign cpu_ack_o = cpu_ack_q;
  assign cpu_err_o = cpu_err_q;
  assign wbm_adr_o = adr_q;
  assign wbm_dat_o = dat_q;
  assign wbm_sel_o = sel_q;
  assign wbm_we_o  = we_q;
  assign wbm_cyc_o = cyc_q;
  assign wbm_stb_o = stb_q;
  assign wbm_cti_o = cti_q;
  assign wbm_bte_o = bte_q;
  assign busy_o    = busy_q;

endmodule

// File: tb/tb_mor1kx_bus_if_wbn.sv
// Bench for mor1kx_bus_if_wbn (DW=32, L=8, RETRY_MAX=3): scripted/random slave responses
// checked against a transfer-level model of the expected Wishbone beats and CPU responses.
module tb_mor1kx_bus_if_wbn;

  localparam int DW   = 32;
  localparam int L    = 8;
  localparam int RMAX = 3;
  localparam logic [31:0] BLK_MASK = 32'(L * DW / 8 - 1);

  localparam logic [2:0] K_ACK = 3'd0, K_ERR = 3'd1, K_RTY = 3'd2, K_ERRACK = 3'd3, K_ACKRTY = 3'd4;

  typedef struct packed {
    logic [2:0]  kind;
    logic [1:0]  dly;
    logic [31:0] dat;
  } resp_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic [2:0]  cti;
    logic [1:0]  bte;
  } att_t;

  logic        clk, rst_n;
  logic [31:0] cpu_adr_i, cpu_dat_i, cpu_dat_o;
  logic        cpu_req_i, cpu_we_i, cpu_burst_i, cpu_ack_o, cpu_err_o;
  logic [3:0]  cpu_bsel_i, wbm_sel_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
  logic        wbm_we_o, wbm_cyc_o, wbm_stb_o, wbm_ack_i, wbm_err_i, wbm_rty_i, busy_o;
  logic [2:0]  wbm_cti_o;
  logic [1:0]  wbm_bte_o;

  mor1kx_bus_if_wbn #(
    .DATA_WIDTH(32), .ADDR_WIDTH(32), .MODE("B3_BURST"), .BURST_LENGTH(L), .RETRY_MAX(RMAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_adr_i(cpu_adr_i), .cpu_dat_i(cpu_dat_i), .cpu_req_i(cpu_req_i),
    .cpu_bsel_i(cpu_bsel_i), .cpu_we_i(cpu_we_i), .cpu_burst_i(cpu_burst_i),
    .cpu_dat_o(cpu_dat_o), .cpu_ack_o(cpu_ack_o), .cpu_err_o(cpu_err_o),
    .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
    .wbm_we_o(wbm_we_o), .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o),
    .wbm_cti_o(wbm_cti_o), .wbm_bte_o(wbm_bte_o), .wbm_dat_i(wbm_dat_i),
    .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .busy_o(busy_o)
  );

  resp_t       plan [0:63];
  int          plan_i;
  att_t        att_q [$];
  logic [31:0] ack_q [$];
  int          err_n, both_n, stb_n, gap_n;
  int          n_vec, n_miss;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Slave responder and response monitor; everything sampled on the falling edge.
  initial begin : slave
    bit    in_att;
    int    wcnt;
    resp_t cur;
    in_att = 0; wcnt = 0; cur = '0;
    wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0; wbm_dat_i = '0;
    forever begin
      @(negedge clk);
      if (cpu_ack_o) ack_q.push_back(cpu_dat_o);
      if (cpu_err_o) err_n++;
      if (cpu_ack_o && cpu_err_o) both_n++;
      if (busy_o && !wbm_cyc_o) gap_n++;
      wbm_ack_i = 0; wbm_err_i = 0; wbm_rty_i = 0;
      if (!rst_n || !(wbm_cyc_o && wbm_stb_o)) begin
        in_att = 0;
      end else begin
        stb_n++;
        if (!in_att) begin
          in_att = 1;
          wcnt   = 0;
          if (plan_i < 64) cur = plan[plan_i];
          else begin cur.kind = K_ACK; cur.dly = 2'd0; cur.dat = 32'hBAD0_0000; end
          plan_i++;
        end
        if (wcnt == int'(cur.dly)) begin
          att_q.push_back({wbm_adr_o, wbm_dat_o, wbm_sel_o, wbm_we_o, wbm_cti_o, wbm_bte_o});
          wbm_dat_i = cur.dat;
          case (cur.kind)
            K_ACK:    wbm_ack_i = 1;
            K_ERR:    wbm_err_i = 1;
            K_RTY:    wbm_rty_i = 1;
            K_ERRACK: begin wbm_err_i = 1; wbm_ack_i = 1; end
            default:  begin wbm_ack_i = 1; wbm_rty_i = 1; end
          endcase
          in_att = 0;
        end else begin
          wcnt++;
        end
      end
    end
  end

  task automatic fill_ack();
    for (int i = 0; i < 64; i++) begin
      plan[i].kind = K_ACK; plan[i].dly = 2'd0; plan[i].dat = $urandom;
    end
  endtask

  task automatic fill_random();
    int r;
    for (int i = 0; i < 64; i++) begin
      r = $urandom_range(0, 99);
      plan[i].kind = (r < 70) ? K_ACK : (r < 85) ? K_RTY : (r < 92) ? K_ACKRTY :
                     (r < 96) ? K_ERR : K_ERRACK;
      plan[i].dly  = 2'($urandom_range(0, 2));
      plan[i].dat  = $urandom;
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".ctl"}, {wbm_cyc_o, wbm_stb_o, cpu_ack_o, cpu_err_o, busy_o, wbm_we_o,
                          wbm_cti_o, wbm_bte_o, wbm_sel_o}, '0);
    check({tag, ".adr"}, wbm_adr_o, '0);
    check({tag, ".dat"}, {cpu_dat_o, wbm_dat_o}, '0);
  endtask

  // One CPU transfer against the currently loaded response plan.
  task automatic xfer(input string tag, input logic [31:0] adr, input logic [31:0] dat,
                      input logic [3:0] sel, input logic we, input logic burst);
    att_t        ea [$];
    logic [31:0] eack [$];
    att_t        a;
    resp_t       r;
    bit          is_b, fin;
    int          nb, beat, retries, pi, eerr, estb, egap, t;
    is_b = burst && !we;
    nb = is_b ? L : 1;
    beat = 0; retries = 0; pi = 0; eerr = 0; estb = 0; egap = 1; fin = 0;
    while (!fin) begin
      r = plan[pi];
      pi++;
      a.adr = is_b ? ((adr & ~BLK_MASK) | ((adr + 32'(beat * 4)) & BLK_MASK)) : adr;
      a.dat = dat; a.sel = sel; a.we = we;
      a.cti = (!is_b || beat == nb - 1) ? 3'b111 : 3'b010;
      a.bte = is_b ? 2'b10 : 2'b00;
      ea.push_back(a);
      estb += int'(r.dly) + 1;
      if (r.kind == K_ERR || r.kind == K_ERRACK) begin
        eerr = 1; fin = 1;
      end else if (r.kind == K_RTY) begin
        if (retries == RMAX) begin eerr = 1; fin = 1; end
        else begin retries++; egap++; end
      end else begin
        eack.push_back(r.dat);
        retries = 0;
        beat++;
        if (beat == nb) fin = 1;
      end
    end

    @(negedge clk);
    att_q.delete(); ack_q.delete();
    err_n = 0; both_n = 0; stb_n = 0; gap_n = 0; plan_i = 0;
    cpu_adr_i = adr; cpu_dat_i = dat; cpu_bsel_i = sel; cpu_we_i = we; cpu_burst_i = burst;
    cpu_req_i = 1;
    @(negedge clk);
    cpu_req_i = 0;
    cpu_adr_i = $urandom; cpu_dat_i = $urandom; cpu_bsel_i = 4'($urandom);
    cpu_we_i = 1'($urandom); cpu_burst_i = 1'($urandom);
    check({tag, ".start"}, {wbm_cyc_o, wbm_stb_o, busy_o}, 3'b111);
    t = 0;
    while (busy_o && t < 500) begin
      @(negedge clk);
      t++;
    end
    check({tag, ".busy_end"}, busy_o, 1'b0);
    check({tag, ".cyc_end"}, wbm_cyc_o, 1'b0);
    check({tag, ".n_beats"}, att_q.size(), ea.size());
    for (int i = 0; i < ea.size(); i++)
      if (i < att_q.size()) check($sformatf("%s.beat%0d", tag, i), att_q[i], ea[i]);
    check({tag, ".n_acks"}, ack_q.size(), eack.size());
    for (int i = 0; i < eack.size(); i++)
      if (i < ack_q.size()) check($sformatf("%s.ack%0d", tag, i), ack_q[i], eack[i]);
    check({tag, ".n_err"}, err_n, eerr);
    check({tag, ".ack_and_err"}, both_n, 0);
    check({tag, ".stb_cycles"}, stb_n, estb);
    check({tag, ".cyc_low_cycles"}, gap_n, egap);
  endtask

  initial begin : main
    int t;
    n_vec = 0; n_miss = 0; plan_i = 0;
    err_n = 0; both_n = 0; stb_n = 0; gap_n = 0;
    cpu_adr_i = '0; cpu_dat_i = '0; cpu_req_i = 0; cpu_bsel_i = '0;
    cpu_we_i = 0; cpu_burst_i = 0;
    fill_ack();
    rst_n = 0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst_n = 1;
    @(negedge clk);
    check_idle_outputs("post_reset");

    fill_ack();
    plan[0].dly = 2'd2;
    xfer("single_wr", 32'h100, 32'hDEAD_BEEF, 4'hF, 1'b1, 1'b0);

    fill_ack();
    xfer("burst_rd", 32'h1018, 32'h0, 4'hF, 1'b0, 1'b1);

    fill_ack();
    plan[2].kind = K_RTY;
    xfer("burst_rty", 32'h2000, 32'h0, 4'hF, 1'b0, 1'b1);

    fill_ack();
    for (int i = 0; i < 4; i++) plan[i].kind = K_RTY;
    xfer("rty_exhaust", 32'h3004, 32'h0, 4'hF, 1'b0, 1'b1);

    fill_ack();
    plan[5].kind = K_ERRACK;
    xfer("err_ack_b5", 32'h4010, 32'h0, 4'hF, 1'b0, 1'b1);
    fill_ack();
    xfer("after_err", 32'h4400, 32'h0, 4'h3, 1'b0, 1'b0);

    for (int n = 0; n < 40; n++) begin
      fill_random();
      xfer($sformatf("rnd%0d", n), $urandom & 32'hFFFF_FFFC, $urandom, 4'($urandom_range(1, 15)),
           1'($urandom), 1'($urandom));
    end

    // Asynchronous reset in the middle of a burst.
    fill_ack();
    @(negedge clk);
    att_q.delete(); plan_i = 0;
    cpu_adr_i = 32'h5008; cpu_we_i = 0; cpu_burst_i = 1; cpu_bsel_i = 4'hF; cpu_req_i = 1;
    @(negedge clk);
    cpu_req_i = 0;
    t = 0;
    while (att_q.size() < 3 && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("rst_mid.reached", att_q.size() >= 3, 1'b1);
    @(posedge clk);
    #2;
    check("rst_mid.pre", {wbm_cyc_o, wbm_stb_o, cpu_ack_o, busy_o}, 4'b1111);
    rst_n = 0;
    #1;
    check_idle_outputs("rst_mid.async");
    repeat (3) @(negedge clk);
    check_idle_outputs("rst_mid.held");
    rst_n = 1;
    repeat (2) @(negedge clk);
    check("rst_mid.no_resume", {wbm_cyc_o, busy_o}, 2'b00);
    fill_ack();
    xfer("rst_then_rd", 32'h0, 32'h0, 4'hF, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
